// File: rtl/udp_packet_builder.sv
// Builds an Ethernet II + IPv4 + UDP frame from a header descriptor and an FWFT payload stream.
// Latency: the first header byte is presented 12 cycles after descriptor accept. Every byte moves only while full is low.
// Backpressure: full stalls every state and dout holds. Define UDP_BUILDER_PAD_EN to zero-pad frames to MIN_FRAME_BYTES.
module udp_packet_builder #(
  parameter int          DATA_WIDTH        = 8,
  parameter logic [15:0] ETH_TYPE_DEF      = 16'h0800,
  parameter logic [7:0]  TIME_TO_LIVE      = 8'h40,
  parameter logic [7:0]  UDP_PROTOCOL_DEF  = 8'h11,
  parameter logic [15:0] IP_FLAGS_FRAG_DEF = 16'h4000,
  parameter logic [15:0] MAX_PAYLOAD_BYTES = 16'd1472,
  parameter logic [15:0] MIN_FRAME_BYTES   = 16'd60
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [15:0]           payload_len,
  input  logic [47:0]           eth_dst_addr,
  input  logic [47:0]           eth_src_addr,
  input  logic [31:0]           ip_src_addr,
  input  logic [31:0]           ip_dst_addr,
  input  logic [15:0]           udp_src_port,
  input  logic [15:0]           udp_dst_port,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic                  empty,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  wr_en,
  input  logic                  full,
  output logic                  len_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, DRAIN, PAD} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt, len_q, sport_q, dport_q, ip_id, ip_checksum;
  logic [47:0]   eth_dst_q, eth_src_q;
  logic [31:0]   ip_src_q, ip_dst_q;
  logic [19:0]   csum_acc;
  logic [15:0]   total_len, udp_len, csum_word, fold2;
  logic [16:0]   fold1;
  logic [335:0]  hdr_vec, hdr_shift;
  logic          pad_needed, last_byte;
  logic          unused_sof;

  // in_sof carries no information the byte counter does not already have
  assign unused_sof = in_sof;

`ifdef UDP_BUILDER_PAD_EN
  logic drain_pend;
  assign pad_needed = (len_q + 16'd42) < MIN_FRAME_BYTES;
`else
  logic unused_min;
  assign unused_min = |MIN_FRAME_BYTES;
  assign pad_needed = 1'b0;
`endif

  assign total_len = len_q + 16'd28;
  assign udp_len   = len_q + 16'd8;
  assign last_byte = (cnt == len_q - 16'd1);
  assign busy      = (state != IDLE);

  always_comb begin
    case (cnt[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = total_len;
      4'd2:    csum_word = ip_id;
      4'd3:    csum_word = IP_FLAGS_FRAG_DEF;
      4'd4:    csum_word = {TIME_TO_LIVE, UDP_PROTOCOL_DEF};
      4'd6:    csum_word = ip_src_q[31:16];
      4'd7:    csum_word = ip_src_q[15:0];
      4'd8:    csum_word = ip_dst_q[31:16];
      4'd9:    csum_word = ip_dst_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  assign fold1 = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  assign hdr_vec = {eth_dst_q, eth_src_q, ETH_TYPE_DEF, 8'h45, 8'h00, total_len, ip_id,
                    IP_FLAGS_FRAG_DEF, TIME_TO_LIVE, UDP_PROTOCOL_DEF, ip_checksum,
                    ip_src_q, ip_dst_q, sport_q, dport_q, udp_len, 16'h0000};
  assign hdr_shift = hdr_vec << {cnt[5:0], 3'b000};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    dout        = '0;
    out_sof     = 1'b0;
    out_eof     = 1'b0;
    len_err     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          if (payload_len > MAX_PAYLOAD_BYTES) len_err = 1'b1;
          else                                 state_nxt = CSUM;
        end
      end
      CSUM: if (cnt == 16'd10) state_nxt = HDR;
      HDR: begin
        wr_en   = !full;
        dout    = hdr_shift[335:328];
        out_sof = (cnt == 16'd0);
        out_eof = (cnt == 16'd41) && (len_q == 16'd0) && !pad_needed;
        if (wr_en && cnt == 16'd41) begin
          if (len_q != 16'd0)  state_nxt = PAYLOAD;
          else if (pad_needed) state_nxt = PAD;
          else                 state_nxt = IDLE;
        end
      end
      PAYLOAD: begin
        rd_en = !empty && !full;
        wr_en = rd_en;
        dout  = din;
        if (wr_en) begin
          if (in_eof && !last_byte) begin
            // early end of input: close a short frame here
            out_eof   = 1'b1;
            len_err   = 1'b1;
            state_nxt = IDLE;
          end else if (last_byte) begin
            out_eof = !pad_needed;
            len_err = !in_eof;
            if (pad_needed)  state_nxt = PAD;
            else if (in_eof) state_nxt = IDLE;
            else             state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        rd_en = !empty;
        if (!empty && in_eof) state_nxt = IDLE;
      end
`ifdef UDP_BUILDER_PAD_EN
      PAD: begin
        wr_en   = !full;
        out_eof = (cnt == MIN_FRAME_BYTES - 16'd1);
        if (wr_en && out_eof) state_nxt = drain_pend ? DRAIN : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      len_q       <= '0;
      sport_q     <= '0;
      dport_q     <= '0;
      ip_id       <= '0;
      ip_checksum <= '0;
      eth_dst_q   <= '0;
      eth_src_q   <= '0;
      ip_src_q    <= '0;
      ip_dst_q    <= '0;
      csum_acc    <= '0;
`ifdef UDP_BUILDER_PAD_EN
      drain_pend  <= 1'b0;
`endif
    end else begin
      if (wr_en && out_eof) ip_id <= ip_id + 16'd1;
      case (state)
        IDLE: if (start_valid) begin
          len_q     <= payload_len;
          eth_dst_q <= eth_dst_addr;
          eth_src_q <= eth_src_addr;
          ip_src_q  <= ip_src_addr;
          ip_dst_q  <= ip_dst_addr;
          sport_q   <= udp_src_port;
          dport_q   <= udp_dst_port;
          cnt       <= '0;
          csum_acc  <= '0;
        end
        CSUM: if (cnt == 16'd10) begin
          ip_checksum <= ~fold2;
          cnt         <= '0;
        end else begin
          csum_acc <= csum_acc + {4'd0, csum_word};
          cnt      <= cnt + 16'd1;
        end
        HDR:     if (wr_en) cnt <= (cnt == 16'd41) ? 16'd0 : cnt + 16'd1;
        PAYLOAD: if (wr_en) cnt <= cnt + 16'd1;
        PAD:     if (wr_en) cnt <= cnt + 16'd1;
        default: ;
      endcase
`ifdef UDP_BUILDER_PAD_EN
      // PAD counts in whole-frame positions so its end test is a constant
      if (state != PAD && state_nxt == PAD) begin
        cnt        <= len_q + 16'd42;
        drain_pend <= (state == PAYLOAD) && !in_eof;
      end
`endif
    end
  end

endmodule

// File: doc/udp_packet_builder.md
Name: udp_packet_builder

Overview:
- Transmit-side counterpart of the UDP/IPv4/Ethernet frame parser.
- Accepts a per-packet header descriptor plus a payload byte stream from a first-word-fall-through FIFO (din/empty/rd_en/in_sof/in_eof).
- Computes the IPv4 header checksum and emits a complete Ethernet II + IPv4 + UDP frame, one byte per cycle, into an output FIFO (dout/wr_en/full/out_sof/out_eof).

Parameters:
- DATA_WIDTH, 8: byte width of the streams; only 8 is supported.
- ETH_TYPE_DEF, 16'h0800: EtherType field.
- TIME_TO_LIVE, 8'h40: IPv4 TTL field.
- UDP_PROTOCOL_DEF, 8'h11: IPv4 protocol field.
- IP_FLAGS_FRAG_DEF, 16'h4000: flags/fragment word (DF set).
- MAX_PAYLOAD_BYTES, 1472: largest accepted payload_len.
- MIN_FRAME_BYTES, 60: minimum frame length, used only when padding is enabled.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_valid  in  1  descriptor valid
- start_ready  out  1  builder idle, descriptor accepted when start_valid is also high
- payload_len  in  16  UDP payload bytes
- eth_dst_addr  in  48  destination MAC
- eth_src_addr  in  48  source MAC
- ip_src_addr  in  32  source IPv4 address
- ip_dst_addr  in  32  destination IPv4 address
- udp_src_port  in  16  source port
- udp_dst_port  in  16  destination port
- din  in  8  payload byte (FWFT)
- in_sof  in  1  first payload byte
- in_eof  in  1  last payload byte
- empty  in  1  input FIFO empty
- rd_en  out  1  pop input FIFO
- dout  out  8  frame byte
- out_sof  out  1  first frame byte
- out_eof  out  1  last frame byte
- wr_en  out  1  push output FIFO
- full  in  1  output FIFO full
- len_err  out  1  one-cycle error pulse
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0 except start_ready = 1. State IDLE; ip_id counter 0.
- IDLE:
  - start_ready = 1.
  - On start_valid, latch all descriptor fields.
  - If payload_len > MAX_PAYLOAD_BYTES: pulse len_err, stay IDLE, output nothing.
  - Otherwise go to CSUM.
- CSUM (11 cycles):
  - Cycles 1-10: add the ten 16-bit IPv4 header words into a 20-bit accumulator, with the checksum word taken as 0.
  - Cycle 11: fold the carry twice and invert to get ip_checksum.
  - Go to HDR. The first header byte is presented in the 12th cycle after acceptance.
- HDR: emit 42 bytes in network order, using a byte index 0-41.
  - Ethernet: dst(6), src(6), ETH_TYPE_DEF(2).
  - IPv4: 0x45, 0x00, total_len = payload_len+28 (2), ip_id (2), IP_FLAGS_FRAG_DEF (2), TIME_TO_LIVE, UDP_PROTOCOL_DEF, ip_checksum (2), src (4), dst (4).
  - UDP: src port (2), dst port (2), udp_len = payload_len+8 (2), checksum 0x0000 (2).
  - wr_en = !full; the index advances only when wr_en is high. out_sof is on index 0.
- Transition out of HDR:
  - payload_len = 0: out_eof on index 41, then go to IDLE (or PAD).
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - rd_en = wr_en = !empty && !full; dout = din in the same cycle.
  - 16-bit counter runs to payload_len. out_eof on byte payload_len when no padding is needed.
- Length mismatches:
  - in_eof before byte payload_len: out_eof on that byte, pulse len_err, go to IDLE. The frame is short.
  - Byte payload_len without in_eof: pulse len_err, go to DRAIN.
- DRAIN: rd_en = !empty; discard bytes through in_eof, then go to IDLE. wr_en = 0.
- in_sof: ignored when not on the first payload byte (no error).
- ip_id: increments by 1 (wrapping 16 bits) after each completed frame, including short frames.
- Back-pressure: full stalls every state without losing or duplicating bytes. dout holds while full is high.
- Mid-frame reset: immediate return to reset values; a partial frame is not terminated.

Optional Feature:
- Macro: UDP_BUILDER_PAD_EN.
- When defined:
  - Frames shorter than MIN_FRAME_BYTES get a PAD state after the last payload (or header) byte.
  - PAD emits 0x00 bytes until the frame length equals MIN_FRAME_BYTES; out_eof is on the final pad byte.
  - IP and UDP length fields still reflect payload_len.
- When undefined: no PAD state; out_eof is always on the last real byte.

Test Plan:
- Known checksum: payload_len=87, ip_src=C0A80001, ip_dst=C0A800C7, ip_id=0 → bytes 14-25 = 45 00 00 73 00 00 40 00 40 11 B8 61; bytes 38-39 = 00 5F; 129 bytes total; out_eof on byte 129.
- Zero payload: payload_len=0 → 42 bytes, rd_en never high, out_eof on byte 42. With UDP_BUILDER_PAD_EN: 60 bytes, bytes 43-60 = 00.
- Back-pressure: full toggled every other cycle during HDR and PAYLOAD → output byte sequence identical to the unstalled run; empty gaps in the input → no dropped bytes.
- Short payload: payload_len=10, in_eof on the 6th byte → out_eof on frame byte 48, one len_err pulse, next descriptor accepted.
- Long payload: payload_len=4, 9 bytes supplied → out_eof on frame byte 46, len_err pulse, 5 bytes drained with wr_en=0.
- Oversize and ID: payload_len=1473 → len_err pulse, no wr_en. Two valid frames back-to-back → ip_id 0 then 1.
